ahb_lite_master: RTL and testbench
==================================

// Module: ahb_lite_master
// PURPOSE
// AHB-lite initiator that turns single-word command requests into AHB-lite transfers.
// - Drives the AHB slave side of the AHB-to-APB bridge, or any AHB-lite slave.
// - Handles one transfer at a time: address phase, then data phase.
// - Honours HREADY wait states and HRESP ERROR; adds a watchdog for a stalled slave.
// PARAMETERS
// AW       32  address width
// DW       32  data width (HSIZE fixed to word)
// TIMEOUT  16  consecutive HREADY-low cycles before abort; 0 disables the watchdog
// PORTS
// HCLK         in   1   clock, all logic on rising edge
// HRESETn      in   1   reset, asynchronous, active-low
// cmd_valid    in   1   command request
// cmd_ready    out  1   command accepted on edge where cmd_valid && cmd_ready
// cmd_write    in   1   1=write, 0=read
// cmd_addr     in   AW  byte address, must be word aligned
// cmd_wdata    in   DW  write data
// rsp_valid    out  1   one-cycle response strobe
// rsp_rdata    out  DW  read data; 0 for writes/aborts
// rsp_err      out  1   slave ERROR, unaligned address or timeout
// rsp_timeout  out  1   watchdog abort
// HSEL         out  1   slave select, high in address phase only
// HADDR        out  AW  transfer address
// HTRANS       out  2   00 IDLE / 10 NONSEQ (SEQ never issued)
// HWRITE       out  1   transfer direction
// HSIZE        out  3   constant 3'b010
// HWDATA       out  DW  write data, valid in data phase
// HRDATA       in   DW  read data
// HREADY       in   1   transfer-phase complete
// HRESP        in   2   00 OKAY, 01 ERROR
// BEHAVIOUR
// - Reset (async assert, sync deassert), values during and after reset:
//   - State=IDLE; HSEL, HTRANS, HADDR, HWRITE, HWDATA, rsp_* and timeout counter = 0.
//   - HSIZE=010.
//   - cmd_ready=1, since cmd_ready is decoded as (state==IDLE).
// - FSM states: IDLE, ADDR, DATA, RESP. All bus/rsp outputs are registered.
// - IDLE:
//   - Accept a command when cmd_valid is high; capture addr, write and wdata.
//   - cmd_addr[1:0]!=0: go to RESP with rsp_err=1; no bus transfer is issued.
//   - Otherwise go to ADDR.
// - ADDR:
//   - Drive HSEL=1, HTRANS=10, HADDR, HWRITE.
//   - HREADY=0 at edge: hold all address-phase signals stable and stay in ADDR.
//   - HREADY=1 at edge: go to DATA, drop to HSEL=0, HTRANS=00, and drive HWDATA (writes).
// - DATA:
//   - Hold HWDATA stable.
//   - HREADY=1 at edge: capture HRDATA (reads only) and rsp_err=(HRESP==01), then go to RESP.
//   - HRESP=01 with HREADY=0 is the first error cycle: keep waiting; the error completes on the HREADY=1 edge.
// - RESP:
//   - rsp_valid=1 for exactly one cycle with rsp_rdata, rsp_err and rsp_timeout, then go to IDLE.
//   - rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
// - Latency and throughput:
//   - Zero-wait slave: accept@T, ADDR T+1, DATA T+2, rsp_valid T+3, next accept T+4.
//   - Result: 1 transfer per 4 cycles.
//   - Each wait state adds one cycle.
// - Watchdog (TIMEOUT>0):
//   - Counts consecutive HREADY=0 cycles in ADDR or DATA; clears on HREADY=1 or state change.
//   - On reaching TIMEOUT: go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   - Bus outputs go to IDLE: HSEL=0, HTRANS=00.
// - No command is accepted outside IDLE. Command inputs are ignored when cmd_valid=0.
// - Reset mid-transfer drops the transfer; no rsp_valid is produced for it.
// TESTING
// 1. Write 0x10 <- 0xDEADBEEF, HREADY=1 -> ADDR: HTRANS=10, HADDR=0x10, HWRITE=1; DATA: HWDATA=DEADBEEF; rsp_valid at T+3, rsp_err=0.
// 2. Read 0x10, slave 3 wait states then HRDATA=0xDEADBEEF -> rsp_valid at T+6, rsp_rdata=DEADBEEF, rsp_err=0.
// 3. Read 0x20, slave two-cycle ERROR (HRESP=01, HREADY 0 then 1) -> rsp_err=1, rsp_timeout=0, HTRANS stays 00.
// 4. HREADY held 0 in DATA, TIMEOUT=16 -> rsp after 16 low cycles: err=1, timeout=1, rdata=0; next cmd accepted.
// 5. cmd_addr=0x13 -> no NONSEQ on bus, rsp_valid at T+1 with rsp_err=1.
// 6. HRESETn low during a DATA wait -> outputs at reset values immediately, no rsp_valid; next write completes normally.

Source files
------------

// File: rtl/ahb_lite_master_if.sv
// Command/response channel and AHB-lite bus signals of ahb_lite_master.
// The master modport is the initiator view; the slave modport is the bus/client view.
interface ahb_lite_master_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          HSEL;
   logic [AW-1:0] HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [DW-1:0] HWDATA;
   logic [DW-1:0] HRDATA;
   logic          HREADY;
   logic [1:0]    HRESP;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
   );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-lite initiator: one single-word transfer per command (address phase, data phase,
// one-cycle response strobe), with HREADY wait states, HRESP ERROR and a stall watchdog.
module ahb_lite_master #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input logic               HCLK,
   input logic               HRESETn,
   ahb_lite_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   state_t        state, state_d;
   logic          hsel_q, hsel_d;
   logic [1:0]    htrans_q, htrans_d;
   logic [AW-1:0] haddr_q, haddr_d;
   logic          hwrite_q, hwrite_d;
   logic [DW-1:0] hwdata_q, hwdata_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;
   logic          rsp_tmo_q, rsp_tmo_d;
   logic [CW-1:0] wd_q, wd_d;
   logic          wd_hit;
   logic          abort;

   assign wd_hit = (TIMEOUT != 0) && (wd_q == WD_LAST);

   always_comb begin
      state_d     = state;
      hsel_d      = hsel_q;
      htrans_d    = htrans_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hwdata_d    = hwdata_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      rsp_tmo_d   = rsp_tmo_q;
      wd_d        = '0;
      abort       = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_addr[1:0] != 2'b00) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b1;
                  rsp_tmo_d   = 1'b0;
               end else begin
                  state_d  = ADDR;
                  hsel_d   = 1'b1;
                  htrans_d = 2'b10;
                  haddr_d  = bus.cmd_addr;
                  hwrite_d = bus.cmd_write;
                  wdata_d  = bus.cmd_wdata;
               end
            end
         end
         ADDR: begin
            if (bus.HREADY) begin
               state_d  = DATA;
               hsel_d   = 1'b0;
               htrans_d = 2'b00;
               if (hwrite_q) hwdata_d = wdata_q;
            end else if (wd_hit) begin
               abort = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         DATA: begin
            if (bus.HREADY) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = hwrite_q ? '0 : bus.HRDATA;
               rsp_err_d   = (bus.HRESP == 2'b01);
               rsp_tmo_d   = 1'b0;
            end else if (wd_hit) begin
               abort = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Watchdog abort releases the bus and reports a zero-data error response.
      if (abort) begin
         state_d     = RESP;
         hsel_d      = 1'b0;
         htrans_d    = 2'b00;
         rsp_valid_d = 1'b1;
         rsp_rdata_d = '0;
         rsp_err_d   = 1'b1;
         rsp_tmo_d   = 1'b1;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state       <= IDLE;
         hsel_q      <= 1'b0;
         htrans_q    <= 2'b00;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hwdata_q    <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_tmo_q   <= 1'b0;
         wd_q        <= '0;
      end else begin
         state       <= state_d;
         hsel_q      <= hsel_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hwdata_q    <= hwdata_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_tmo_q   <= rsp_tmo_d;
         wd_q        <= wd_d;
      end
   end

   assign bus.cmd_ready   = (state == IDLE);
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_tmo_q;
   assign bus.HSEL        = hsel_q;
   assign bus.HADDR       = haddr_q;
   assign bus.HTRANS      = htrans_q;
   assign bus.HWRITE      = hwrite_q;
   assign bus.HSIZE       = 3'b010;
   assign bus.HWDATA      = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: scripted AHB slave responses, bus-phase checks
// inline, and a response scoreboard holding expected data, flags and arrival cycle.
module tb_ahb_lite_master;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 16;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      logic          tmo;
      int unsigned   due;
   } exp_t;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;
   exp_t        sbq[$];
   exp_t        mon_e;

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   ahb_lite_master_if #(.AW(AW), .DW(DW)) bus ();

   ahb_lite_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   // Response monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge HCLK) begin
      if (bus.rsp_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(mon_e.due));
            chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
            chk("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
            chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(mon_e.tmo));
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      chk("rst_hsel", 64'(bus.HSEL), 64'd0);
      chk("rst_htrans", 64'(bus.HTRANS), 64'd0);
      chk("rst_haddr", 64'(bus.HADDR), 64'd0);
      chk("rst_hwrite", 64'(bus.HWRITE), 64'd0);
      chk("rst_hwdata", 64'(bus.HWDATA), 64'd0);
      chk("rst_hsize", 64'(bus.HSIZE), 64'd2);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
   endtask

   // One command: aw/dw are address/data phase wait states; dw >= TMO stalls until the watchdog fires.
   task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int unsigned aw, input int unsigned dw,
                         input logic [DW-1:0] rd, input logic serr);
      exp_t e;
      logic unal;
      logic tmo;
      unal = (addr[1:0] != 2'b00);
      tmo  = !unal && (dw >= TMO);
      chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      e.rdata = (wr || unal || tmo) ? '0 : rd;
      e.err   = unal || tmo || serr;
      e.tmo   = tmo;
      e.due   = cyc + (unal ? 1 : (tmo ? aw + 2 + TMO : aw + 3 + dw));
      sbq.push_back(e);
      step();
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
      if (unal) begin
         chk("unal_htrans", 64'(bus.HTRANS), 64'd0);
         chk("unal_hsel", 64'(bus.HSEL), 64'd0);
         step();
         return;
      end
      for (int unsigned i = 0; i <= aw; i++) begin
         chk("addr_htrans", 64'(bus.HTRANS), 64'd2);
         chk("addr_hsel", 64'(bus.HSEL), 64'd1);
         chk("addr_haddr", 64'(bus.HADDR), 64'(addr));
         chk("addr_hwrite", 64'(bus.HWRITE), 64'(wr));
         bus.HREADY = (i == aw);
         bus.HRESP  = 2'b00;
         step();
      end
      chk("data_htrans", 64'(bus.HTRANS), 64'd0);
      chk("data_hsel", 64'(bus.HSEL), 64'd0);
      if (tmo) begin
         for (int unsigned i = 0; i < TMO; i++) begin
            bus.HREADY = 1'b0;
            chk("tmo_htrans", 64'(bus.HTRANS), 64'd0);
            if (wr) chk("tmo_hwdata", 64'(bus.HWDATA), 64'(wd));
            step();
         end
      end else begin
         for (int unsigned i = 0; i <= dw; i++) begin
            bus.HREADY = (i == dw);
            bus.HRESP  = serr ? 2'b01 : 2'b00;
            bus.HRDATA = (i == dw) ? rd : $urandom;
            if (wr) chk("data_hwdata", 64'(bus.HWDATA), 64'(wd));
            step();
         end
      end
      bus.HREADY = 1'b1;
      bus.HRESP  = 2'b00;
      bus.HRDATA = '0;
      chk("resp_htrans", 64'(bus.HTRANS), 64'd0);
      step();
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.HRDATA    = '0;
      bus.HREADY    = 1'b1;
      bus.HRESP     = 2'b00;
      repeat (3) step();
      check_reset_vals();
      HRESETn = 1'b1;
      step();

      // Command inputs ignored while cmd_valid is low.
      bus.cmd_addr  = 32'h0000_0080;
      bus.cmd_write = 1'b1;
      repeat (2) step();
      chk("idle_ignore_htrans", 64'(bus.HTRANS), 64'd0);
      chk("idle_ignore_ready", 64'(bus.cmd_ready), 64'd1);

      do_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, '0, 1'b0);
      do_cmd(1'b0, 32'h0000_0010, '0, 0, 3, 32'hDEAD_BEEF, 1'b0);
      do_cmd(1'b0, 32'h0000_0020, '0, 0, 1, '0, 1'b1);
      do_cmd(1'b0, 32'h0000_0030, '0, 0, TMO, 32'h1111_2222, 1'b0);
      do_cmd(1'b1, 32'h0000_0013, 32'h1234_5678, 0, 0, '0, 1'b0);
      do_cmd(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 2, 1, '0, 1'b0);
      do_cmd(1'b0, 32'h0000_0048, '0, 0, 0, 32'h0BAD_F00D, 1'b0);

      // Reset asserted while the slave stalls the data phase.
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h0000_0040;
      bus.cmd_wdata = 32'h5555_AAAA;
      step();
      bus.cmd_valid = 1'b0;
      bus.HREADY    = 1'b1;
      step();
      bus.HREADY = 1'b0;
      repeat (2) step();
      chk("pre_rst_hwdata", 64'(bus.HWDATA), 64'h5555_AAAA);
      HRESETn = 1'b0;
      #1;
      check_reset_vals();
      step();
      HRESETn    = 1'b1;
      bus.HREADY = 1'b1;
      step();
      do_cmd(1'b1, 32'h0000_0050, 32'hA5A5_5A5A, 0, 0, '0, 1'b0);

      repeat (3) step();
      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
